// File: rtl/shift_register_seq.sv
// Sequencing shift register for the divisor datapath: parallel load plus a
// self-timed burst of up to 2*WL one-bit shifts in one of four modes.
module shift_register_seq #(
  parameter int WL = 4,
  localparam int CW = $clog2(2*WL)+1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Load,
  input  logic            Start,
  input  logic [1:0]      Mode,
  input  logic [CW-1:0]   Count,
  input  logic            SerialIn,
  input  logic [2*WL-1:0] d,
  output logic [2*WL-1:0] q,
  output logic            Busy,
  output logic            Done,
  output logic            ShiftOut
);

  localparam int W = 2*WL;
  localparam logic [CW-1:0] W_C = CW'(W);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t        state_r, state_s;
  logic [W-1:0]  q_r, q_s;
  logic          so_r, so_s;
  logic [1:0]    mode_r, mode_s;
  logic [CW-1:0] rem_r, rem_s;
  logic [CW-1:0] n_eff_s;
  logic [W:0]    shift_res_s;

  // One shift step; the result is {expelled bit, new register value}.
  function automatic logic [W:0] shift_f(input logic [W-1:0] qv,
                                         input logic [1:0]   mv,
                                         input logic         sin);
    logic [W:0] r;
    case (mv)
      2'b00:   r = {qv[W-1], qv[W-2:0], sin};
      2'b01:   r = {qv[0], sin, qv[W-1:1]};
      2'b10:   r = {qv[0], qv[W-1], qv[W-1:1]};
      2'b11:   r = {qv[W-1], qv[W-2:0], qv[W-1]};
      default: r = {1'b0, qv};
    endcase
    return r;
  endfunction

  assign n_eff_s     = (Count > W_C) ? W_C : Count;
  assign shift_res_s = shift_f(q_r, mode_r, SerialIn);

  // Next-state and datapath decode.
  always_comb begin
    state_s = state_r;
    q_s     = q_r;
    so_s    = so_r;
    mode_s  = mode_r;
    rem_s   = rem_r;
    case (state_r)
      IDLE: begin
        if (Load) begin
          q_s  = d;
          so_s = 1'b0;
        end else if (Start) begin
          mode_s = Mode;
          if (n_eff_s == {CW{1'b0}}) begin
            state_s = DONE;
          end else begin
            rem_s   = n_eff_s;
            state_s = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        q_s   = shift_res_s[W-1:0];
        so_s  = shift_res_s[W];
        rem_s = rem_r - CW'(1);
        if (rem_r == CW'(1)) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any burst without a Done.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      q_r     <= {W{1'b0}};
      so_r    <= 1'b0;
      mode_r  <= 2'b00;
      rem_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      q_r     <= q_s;
      so_r    <= so_s;
      mode_r  <= mode_s;
      rem_r   <= rem_s;
    end
  end

  assign q        = q_r;
  assign ShiftOut = so_r;
  assign Busy     = (state_r == SHIFT);
  assign Done     = (state_r == DONE);

endmodule

// File: tb/tb_shift_register_seq.sv
// Directed self-checking bench for shift_register_seq with WL=4.
module tb_shift_register_seq;

  localparam int WL = 4;
  localparam int CW = $clog2(2*WL)+1;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            Load = 1'b0;
  logic            Start = 1'b0;
  logic [1:0]      Mode = 2'b00;
  logic [CW-1:0]   Count = '0;
  logic            SerialIn = 1'b0;
  logic [2*WL-1:0] d = '0;
  logic [2*WL-1:0] q;
  logic            Busy, Done, ShiftOut;

  int checks = 0;
  int passed = 0;

  shift_register_seq #(.WL(WL)) dut (
    .CLK(CLK), .RST(RST), .Load(Load), .Start(Start), .Mode(Mode),
    .Count(Count), .SerialIn(SerialIn), .d(d), .q(q), .Busy(Busy),
    .Done(Done), .ShiftOut(ShiftOut)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eq, input logic eso,
                         input logic ebusy, input logic edone);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".so"}, 32'(ShiftOut), 32'(eso));
    chk({tag, ".busy"}, 32'(Busy), 32'(ebusy));
    chk({tag, ".done"}, 32'(Done), 32'(edone));
  endtask

  initial begin
    tick();
    tick();
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;

    // Mode 00 logical left, count 3
    Load = 1'b1; d = 8'h81; tick(); Load = 1'b0;
    chk_all("ld81", 8'h81, 1'b0, 1'b0, 1'b0);
    Start = 1'b1; Mode = 2'b00; Count = 4'd3; SerialIn = 1'b1; tick(); Start = 1'b0;
    chk_all("ll.e0", 8'h81, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("ll.e1", 8'h03, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("ll.e2", 8'h07, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("ll.e3", 8'h0F, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("ll.idle", 8'h0F, 1'b0, 1'b0, 1'b0);

    // Mode 10 arithmetic right, then mode 01 logical right
    Load = 1'b1; d = 8'h90; tick(); Load = 1'b0;
    Start = 1'b1; Mode = 2'b10; Count = 4'd2; SerialIn = 1'b1; tick(); Start = 1'b0;
    tick(); chk_all("ar.e1", 8'hC8, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("ar.e2", 8'hE4, 1'b0, 1'b0, 1'b1);
    tick();
    Load = 1'b1; d = 8'h90; tick(); Load = 1'b0;
    Start = 1'b1; Mode = 2'b01; Count = 4'd2; SerialIn = 1'b0; tick(); Start = 1'b0;
    tick(); chk_all("lr.e1", 8'h48, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("lr.e2", 8'h24, 1'b0, 1'b0, 1'b1);
    tick();

    // Mode 11 rotate, count 15 clamps to 8; commands during burst/done ignored
    Load = 1'b1; d = 8'hA5; tick(); Load = 1'b0;
    Start = 1'b1; Mode = 2'b11; Count = 4'd15; tick();
    Load = 1'b1; d = 8'hFF; Mode = 2'b00; Count = 4'd1;
    tick(); chk_all("rot.e1", 8'h4B, 1'b1, 1'b1, 1'b0);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk("rot.busy", 32'(Busy), 32'(i < 8));
      chk("rot.done", 32'(Done), 32'(i == 8));
    end
    chk_all("rot.e8", 8'hA5, 1'b1, 1'b0, 1'b1);
    tick(); Load = 1'b0; Start = 1'b0;
    chk_all("rot.after", 8'hA5, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("rot.idle", 8'hA5, 1'b1, 1'b0, 1'b0);

    // Count 0, then simultaneous Load and Start
    Load = 1'b1; d = 8'h5A; tick(); Load = 1'b0;
    chk("ld5a.so", 32'(ShiftOut), 32'h0);
    Start = 1'b1; Mode = 2'b00; Count = 4'd0; tick(); Start = 1'b0;
    chk_all("n0.e0", 8'h5A, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("n0.e1", 8'h5A, 1'b0, 1'b0, 1'b0);
    Load = 1'b1; Start = 1'b1; d = 8'h3C; Count = 4'd3; tick(); Load = 1'b0; Start = 1'b0;
    chk_all("ldst", 8'h3C, 1'b0, 1'b0, 1'b0);
    tick(); chk_all("ldst.next", 8'h3C, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-burst, then a fresh burst
    Load = 1'b1; d = 8'h01; tick(); Load = 1'b0;
    Start = 1'b1; Mode = 2'b00; Count = 4'd6; SerialIn = 1'b0; tick(); Start = 1'b0;
    tick(); chk("rs.e1", 32'(q), 32'h02);
    tick(); chk("rs.e2", 32'(q), 32'h04);
    #2 RST = 1'b1;
    #1 chk_all("rs.async", 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    RST = 1'b0;
    tick(); chk_all("rs.post1", 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); chk_all("rs.post2", 8'h00, 1'b0, 1'b0, 1'b0);
    Start = 1'b1; Mode = 2'b00; Count = 4'd1; SerialIn = 1'b1; tick(); Start = 1'b0;
    chk_all("new.e0", 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("new.e1", 8'h01, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("new.idle", 8'h01, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/shift_register_seq.md
# shift_register_seq

Parametrised sequencing shift register for the Divisor datapath. It holds a 2*WL-bit word and accepts a parallel load. On a single Start strobe it runs a burst of 0..2*WL one-bit shifts, one per clock, in one of four modes. It raises Busy for the burst and pulses Done at the end, so the divider controller no longer has to issue and count individual shift commands.

## Interface
- WL, default 4: half-width; register width is 2*WL.
- CW, localparam = $clog2(2*WL)+1: width of the Count port.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- Load  in  1  parallel load of d; accepted only in IDLE.
- Start  in  1  begin a shift burst; accepted only in IDLE.
- Mode  in  2  burst mode, latched at Start:
  - 00 logical left
  - 01 logical right
  - 10 arithmetic right
  - 11 rotate left
- Count  in  CW  number of shifts, latched at Start.
- SerialIn  in  1  fill bit for modes 00/01; sampled on every shift edge, not latched.
- d  in  2*WL  parallel load data.
- q  out  2*WL  register contents.
- Busy  out  1  high while in SHIFT.
- Done  out  1  one-cycle pulse in DONE.
- ShiftOut  out  1  bit expelled by the most recent shift.

## Operation
- Reset (async, RST=1): q=0, ShiftOut=0, Busy=0, Done=0, state=IDLE, internal counter=0. Reset dominates everything and can interrupt a burst at any point; the interrupted burst produces no Done.
- FSM: IDLE -> SHIFT -> DONE -> IDLE. Busy = (state==SHIFT). Done = (state==DONE). Both are decoded from registered state.
- IDLE:
  - Load=1: q<=d, ShiftOut<=0. Load has priority, so Start in the same cycle is ignored.
  - Start=1, Load=0: latch Mode and the effective count N = min(Count, 2*WL).
    - N=0: go to DONE, q unchanged.
    - N>0: go to SHIFT with remaining=N.
- SHIFT: each edge performs one shift and decrements remaining. On the edge where remaining reaches 0, the state goes to DONE. Load and Start are ignored.
- Shift rules (W=2*WL):
  - 00: q<={q[W-2:0],SerialIn}, ShiftOut<=q[W-1].
  - 01: q<={SerialIn,q[W-1:1]}, ShiftOut<=q[0].
  - 10: q<={q[W-1],q[W-1:1]}, ShiftOut<=q[0].
  - 11: q<={q[W-2:0],q[W-1]}, ShiftOut<=q[W-1].
- DONE: lasts exactly one cycle, then IDLE. Load and Start are ignored during this cycle.
- q and ShiftOut hold their values in every cycle where no load or shift occurs.

## Timing
- Start is sampled at edge E0. For N>0:
  - q changes at edges E1..EN.
  - Busy is high from after E0 until EN.
  - Done is high from EN to EN+1.
  - The next Start or Load is accepted at EN+2.
- N=0: Done is high from E0 to E1, Busy never rises, and q is unchanged.
- Total occupancy is N+2 cycles from Start acceptance to the next accepted command.
- Load latency: q=d visible one cycle after the sampling edge.
- Count values above 2*WL are clamped to 2*WL. For WL=4, Count=15 behaves as 8.

## Test plan
- Reset: assert RST mid-cycle (asynchronously) -> q=0x00, ShiftOut=0, Busy=0, Done=0 immediately, before the next clock edge.
- WL=4, Load d=0x81, then Start Mode=00 Count=3 SerialIn=1 -> q=0x03, 0x07, 0x0F on E1..E3; ShiftOut=1,0,0; Busy high 3 cycles; Done high 1 cycle after E3.
- Load 0x90, Start Mode=10 Count=2 -> q=0xC8, then 0xE4; ShiftOut=0; then Load 0x90, Mode=01 Count=2 SerialIn=0 -> q=0x48, then 0x24.
- Load 0xA5, Start Mode=11 Count=15 -> clamped to 8; Busy high 8 cycles; final q=0xA5; ShiftOut=1; Start and Load pulsed during Busy and during Done are ignored.
- Start Count=0 with q=0x5A -> Done next cycle, Busy stays 0, q=0x5A; Load and Start in the same cycle -> load taken, no burst.
- Start Mode=00 Count=6 from q=0x01 SerialIn=0, assert RST after E2 -> q=0, Busy=0, no Done pulse; a new Start after reset release runs normally.
